rob_finish_arb: RTL and testbench
=================================

ROB_FINISH_ARB -- requirements
Module: rob_finish_arb

Interface
REQ-001 Parameter NREQ, default 4, number of finishing requesters (functional units); fixed at 4 for this revision.
REQ-002 Parameter DATA_W, default 32, width of instruction tag and result value.
REQ-003 Parameter FLUSH_HOLD, default 2, cycles of finish blackout after a flush issue (legal range 1..15).
REQ-004 clock  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-low (0 = reset asserted); deassertion sampled on clock.
REQ-006 req_valid  input  NREQ  requester i presents a finished instruction.
REQ-007 req_instr  input  NREQ*DATA_W  instruction tags, requester i in bits [i*DATA_W +: DATA_W].
REQ-008 req_val  input  NREQ*DATA_W  result values, same packing.
REQ-009 req_ready  output  NREQ  one-hot grant; transfer when req_valid[i] & req_ready[i].
REQ-010 flush_valid  input  1  flush request; flush_instr  input  DATA_W  tag to flush.
REQ-011 flush_ready  output  1  flush accepted this cycle when flush_valid & flush_ready.
REQ-012 finishing_instr, instr_to_finish (DATA_W), finish_val (DATA_W)  output  registered finish port to ROB.
REQ-013 flushing_instr, instr_to_flush (DATA_W)  output  registered flush port to ROB.
REQ-014 grant_id  output  2  index of last granted requester; hold  output  1  high while in HOLD state.

Function
REQ-015 Two states: ARB, HOLD; counter hold_cnt (4 bits).
REQ-016 flush_ready SHALL be 1 in both states (flush always accepted, never stalls).
REQ-017 Flush accept at edge -> next cycle flushing_instr=1, instr_to_flush=captured flush_instr, finishing_instr=0; state<=HOLD, hold_cnt<=FLUSH_HOLD.
REQ-018 Flush accepted while in HOLD SHALL issue again and reload hold_cnt to FLUSH_HOLD.
REQ-019 HOLD: req_ready=0; hold_cnt decrements each cycle without flush; at hold_cnt==1 and no flush, state<=ARB next edge.
REQ-020 ARB with flush_valid=1: req_ready=0 (flush priority over finish in same cycle).
REQ-021 ARB with flush_valid=0: req_ready one-hot to first valid requester searching from rr_ptr upward modulo NREQ; all zero if no valid.
REQ-022 req_ready is combinational from req_valid, rr_ptr, state, flush_valid; SHALL not depend on req_instr/req_val.
REQ-023 On transfer of requester w: next cycle finishing_instr=1, instr_to_finish=req_instr[w], finish_val=req_val[w], grant_id=w; rr_ptr<=(w+1) mod NREQ.
REQ-024 No transfer: finishing_instr=0 next cycle; instr_to_finish/finish_val hold previous values; rr_ptr unchanged.
REQ-025 flushing_instr and finishing_instr are single-cycle pulses, never both 1 in the same cycle.
REQ-026 Latency: accept edge to ROB-port visibility exactly one cycle; max one finish per cycle; sustained throughput 1/cycle in ARB.
REQ-027 Requester holding req_valid without ready SHALL be granted within NREQ consecutive ARB cycles lacking flush (no starvation).

Reset
REQ-028 reset=0 SHALL asynchronously force: state=ARB, hold_cnt=0, rr_ptr=0, grant_id=0, finishing_instr=0, flushing_instr=0, instr_to_finish=0, finish_val=0, instr_to_flush=0.
REQ-029 While reset=0: req_ready=0, flush_ready=0.
REQ-030 Reset mid-HOLD or mid-transfer SHALL drop the pending issue; no pulse after deassertion unless a new handshake occurs.

Structure
REQ-031 Shared package rob_pkg holds NREQ, DATA_W, FLUSH_HOLD defaults and the ARB/HOLD state encoding.
REQ-032 One sub-module rr_arbiter: combinational NREQ-way round-robin pick (req, ptr -> one-hot grant, index); all state stays in rob_finish_arb.

Verification
REQ-033 After reset, req_valid=4'b1111 with tags 10,11,12,13 held -> finishes 10,11,12,13 on four consecutive cycles, grant_id 0,1,2,3.
REQ-034 req_valid=4'b0100, tag 7, val 99 -> next cycle finishing_instr=1, instr_to_finish=7, finish_val=99; rr_ptr=3.
REQ-035 flush_valid=1 flush_instr=5 with req_valid=4'b0001 same cycle -> req_ready=0; next cycle flushing_instr=1, instr_to_flush=5; finishes blocked 2 cycles; requester 0 finishes in 4th cycle after flush accept.
REQ-036 Second flush (tag 6) during HOLD -> second flushing_instr pulse, hold counter reloaded to 2.
REQ-037 reset=0 asserted mid-cycle during HOLD -> all outputs 0 immediately; after release, req_valid=4'b1000 -> granted next edge.
REQ-038 Requester 3 held valid with requesters 0-2 continuously valid -> requester 3 granted within 4 cycles.

Source files
------------

// File: rtl/rob_pkg.sv
// Shared defaults and state encoding for the ROB finish/flush arbiter.
// Imported by rob_finish_arb and rr_arbiter.
package rob_pkg;

   localparam int NREQ_DEF       = 4;
   localparam int DATA_W_DEF     = 32;
   localparam int FLUSH_HOLD_DEF = 2;
   localparam int HOLD_CNT_W     = 4;

   typedef enum logic {
      ST_ARB  = 1'b0,
      ST_HOLD = 1'b1
   } state_t;

endpackage : rob_pkg

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: the first set request at or above ptr, wrapping modulo NREQ.
// Stateless; the pointer lives in the parent.
module rr_arbiter import rob_pkg::*; #(
   parameter int NREQ  = NREQ_DEF,
   parameter int IDX_W = $clog2(NREQ)
) (
   input  logic [NREQ-1:0]  req,
   input  logic [IDX_W-1:0] ptr,
   output logic [NREQ-1:0]  gnt,
   output logic [IDX_W-1:0] idx
);

   always_comb begin
      logic [IDX_W-1:0] j;
      logic             found;
      // NOTE: every output gets a default before the loop so no latch is inferred.
      gnt   = '0;
      idx   = '0;
      found = 1'b0;
      j     = '0;
      // NREQ is a power of two, so the IDX_W-bit add wraps modulo NREQ for free.
      for (int k = 0; k < NREQ; k++) begin
         j = ptr + IDX_W'(k);
         if (!found && req[j]) begin
            gnt[j] = 1'b1;
            idx    = j;
            found  = 1'b1;
         end
      end
   end

endmodule : rr_arbiter

// File: rtl/rob_finish_arb.sv
// Arbitrates NREQ finishing functional units onto one registered ROB finish port;
// flushes always win and open a FLUSH_HOLD-cycle finish blackout.
module rob_finish_arb import rob_pkg::*; #(
   parameter int NREQ       = NREQ_DEF,
   parameter int DATA_W     = DATA_W_DEF,
   parameter int FLUSH_HOLD = FLUSH_HOLD_DEF
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [NREQ-1:0]          req_valid,
   input  logic [NREQ*DATA_W-1:0]   req_instr,
   input  logic [NREQ*DATA_W-1:0]   req_val,
   output logic [NREQ-1:0]          req_ready,
   input  logic                     flush_valid,
   input  logic [DATA_W-1:0]        flush_instr,
   output logic                     flush_ready,
   output logic                     finishing_instr,
   output logic [DATA_W-1:0]        instr_to_finish,
   output logic [DATA_W-1:0]        finish_val,
   output logic                     flushing_instr,
   output logic [DATA_W-1:0]        instr_to_flush,
   output logic [$clog2(NREQ)-1:0]  grant_id,
   output logic                     hold
);

   localparam int IDX_W = $clog2(NREQ);

   state_t                  state_q, state_d;
   logic [HOLD_CNT_W-1:0]   hold_cnt_q, hold_cnt_d;
   logic [IDX_W-1:0]        rr_ptr;
   logic [NREQ-1:0]         arb_gnt;
   logic [IDX_W-1:0]        arb_idx;
   logic                    flush_fire;
   logic                    finish_fire;
   logic [DATA_W-1:0]       instr_lane [NREQ];
   logic [DATA_W-1:0]       val_lane   [NREQ];

   rr_arbiter #(
      .NREQ  (NREQ),
      .IDX_W (IDX_W)
   ) u_rr (
      .req (req_valid),
      .ptr (rr_ptr),
      .gnt (arb_gnt),
      .idx (arb_idx)
   );

   always_comb begin
      for (int i = 0; i < NREQ; i++) begin
         instr_lane[i] = req_instr[i*DATA_W +: DATA_W];
         val_lane[i]   = req_val[i*DATA_W +: DATA_W];
      end
   end

   assign flush_fire  = flush_valid & flush_ready;
   assign finish_fire = |(req_valid & req_ready);

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_ARB;
         hold_cnt_q <= '0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
         state_q    <= state_d;
         hold_cnt_q <= hold_cnt_d;
      end
   end

   // Next state: a flush (re)starts the blackout from any state.
   always_comb begin
      state_d    = state_q;
      hold_cnt_d = hold_cnt_q;
      if (flush_fire) begin
         state_d    = ST_HOLD;
         hold_cnt_d = HOLD_CNT_W'(FLUSH_HOLD);
      end else if (state_q == ST_HOLD) begin
         hold_cnt_d = hold_cnt_q - 1'b1;
         if (hold_cnt_q <= HOLD_CNT_W'(1)) begin
            state_d = ST_ARB;
         end
      end
   end

   // Outputs: grants only in ARB with no competing flush; nothing is accepted under reset.
   always_comb begin
      req_ready   = '0;
      flush_ready = rst_n;
      hold        = (state_q == ST_HOLD);
      if (rst_n && state_q == ST_ARB && !flush_valid) begin
         req_ready = arb_gnt;
      end
   end

   // Registered ROB ports; finish payload and grant_id hold between transfers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         finishing_instr <= 1'b0;
         flushing_instr  <= 1'b0;
         instr_to_finish <= '0;
         finish_val      <= '0;
         instr_to_flush  <= '0;
         grant_id        <= '0;
         rr_ptr          <= '0;
      end else begin
         finishing_instr <= 1'b0;
         flushing_instr  <= 1'b0;
         if (flush_fire) begin
            flushing_instr <= 1'b1;
            instr_to_flush <= flush_instr;
         end else if (finish_fire) begin
            finishing_instr <= 1'b1;
            instr_to_finish <= instr_lane[arb_idx];
            finish_val      <= val_lane[arb_idx];
            grant_id        <= arb_idx;
            rr_ptr          <= arb_idx + IDX_W'(1);
         end
      end
   end

endmodule : rob_finish_arb

// File: tb/tb_rob_finish_arb.sv
// Directed bench for rob_finish_arb: a vector table for the main sequence plus
// hand-written reset-during-hold and fairness sequences.
module tb_rob_finish_arb;

   localparam int NREQ   = 4;
   localparam int DATA_W = 32;

   logic                   clk;
   logic                   rst_n;
   logic [NREQ-1:0]        req_valid;
   logic [NREQ*DATA_W-1:0] req_instr;
   logic [NREQ*DATA_W-1:0] req_val;
   logic [NREQ-1:0]        req_ready;
   logic                   flush_valid;
   logic [DATA_W-1:0]      flush_instr;
   logic                   flush_ready;
   logic                   finishing_instr;
   logic [DATA_W-1:0]      instr_to_finish;
   logic [DATA_W-1:0]      finish_val;
   logic                   flushing_instr;
   logic [DATA_W-1:0]      instr_to_flush;
   logic [1:0]             grant_id;
   logic                   hold;

   int n_cmp  = 0;
   int n_fail = 0;

   rob_finish_arb #(.NREQ(NREQ), .DATA_W(DATA_W), .FLUSH_HOLD(2)) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .req_valid       (req_valid),
      .req_instr       (req_instr),
      .req_val         (req_val),
      .req_ready       (req_ready),
      .flush_valid     (flush_valid),
      .flush_instr     (flush_instr),
      .flush_ready     (flush_ready),
      .finishing_instr (finishing_instr),
      .instr_to_finish (instr_to_finish),
      .finish_val      (finish_val),
      .flushing_instr  (flushing_instr),
      .instr_to_flush  (instr_to_flush),
      .grant_id        (grant_id),
      .hold            (hold)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish (got timeout, required $finish)");
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic [3:0]  rv;
      logic [31:0] tbase;
      logic [31:0] vbase;
      logic        fv;
      logic [31:0] ftag;
      logic [3:0]  e_ready;
      logic        e_hold;
      logic        e_fin;
      logic [31:0] e_itf;
      logic [31:0] e_fval;
      logic [1:0]  e_gid;
      logic        e_fl;
      logic [31:0] e_itfl;
   } vec_t;

   localparam int NVEC = 21;
   vec_t vecs [NVEC];

   function automatic vec_t mk(logic [3:0] rv, logic [31:0] tb, logic [31:0] vb,
                               logic fv, logic [31:0] ft, logic [3:0] rdy, logic hd,
                               logic fin, logic [31:0] itf, logic [31:0] fval,
                               logic [1:0] gid, logic fl, logic [31:0] itfl);
      vec_t v;
      v.rv = rv; v.tbase = tb; v.vbase = vb; v.fv = fv; v.ftag = ft;
      v.e_ready = rdy; v.e_hold = hd; v.e_fin = fin; v.e_itf = itf;
      v.e_fval = fval; v.e_gid = gid; v.e_fl = fl; v.e_itfl = itfl;
      return v;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Lane i carries tag tb+i and value vb+i.
   task automatic drive(input logic [3:0] rv, input logic [31:0] tb, input logic [31:0] vb,
                        input logic fv, input logic [31:0] ft);
      req_valid   = rv;
      flush_valid = fv;
      flush_instr = ft;
      for (int i = 0; i < NREQ; i++) begin
         req_instr[i*DATA_W +: DATA_W] = tb + 32'(i);
         req_val[i*DATA_W +: DATA_W]   = vb + 32'(i);
      end
   endtask

   initial begin
      bit got3;

      vecs[0]  = mk(4'hF, 10, 100, 0, 0, 4'b0001, 0, 1, 10, 100, 0, 0, 0);
      vecs[1]  = mk(4'hF, 10, 100, 0, 0, 4'b0010, 0, 1, 11, 101, 1, 0, 0);
      vecs[2]  = mk(4'hF, 10, 100, 0, 0, 4'b0100, 0, 1, 12, 102, 2, 0, 0);
      vecs[3]  = mk(4'hF, 10, 100, 0, 0, 4'b1000, 0, 1, 13, 103, 3, 0, 0);
      vecs[4]  = mk(4'h0, 10, 100, 0, 0, 4'b0000, 0, 0, 13, 103, 3, 0, 0);
      vecs[5]  = mk(4'h4,  5,  97, 0, 0, 4'b0100, 0, 1,  7,  99, 2, 0, 0);
      vecs[6]  = mk(4'hF, 20, 200, 0, 0, 4'b1000, 0, 1, 23, 203, 3, 0, 0);
      vecs[7]  = mk(4'h1, 30, 300, 1, 5, 4'b0000, 0, 0, 23, 203, 3, 1, 5);
      vecs[8]  = mk(4'h1, 30, 300, 0, 0, 4'b0000, 1, 0, 23, 203, 3, 0, 5);
      vecs[9]  = mk(4'h1, 30, 300, 0, 0, 4'b0000, 1, 0, 23, 203, 3, 0, 5);
      vecs[10] = mk(4'h1, 30, 300, 0, 0, 4'b0001, 0, 1, 30, 300, 0, 0, 5);
      vecs[11] = mk(4'h0, 30, 300, 1, 5, 4'b0000, 0, 0, 30, 300, 0, 1, 5);
      vecs[12] = mk(4'h0, 30, 300, 1, 6, 4'b0000, 1, 0, 30, 300, 0, 1, 6);
      vecs[13] = mk(4'h0, 30, 300, 0, 0, 4'b0000, 1, 0, 30, 300, 0, 0, 6);
      vecs[14] = mk(4'h0, 30, 300, 0, 0, 4'b0000, 1, 0, 30, 300, 0, 0, 6);
      vecs[15] = mk(4'h2, 40, 400, 0, 0, 4'b0010, 0, 1, 41, 401, 1, 0, 6);
      vecs[16] = mk(4'hF, 50, 500, 0, 0, 4'b0100, 0, 1, 52, 502, 2, 0, 6);
      vecs[17] = mk(4'hF, 50, 500, 0, 0, 4'b1000, 0, 1, 53, 503, 3, 0, 6);
      vecs[18] = mk(4'hF, 50, 500, 0, 0, 4'b0001, 0, 1, 50, 500, 0, 0, 6);
      vecs[19] = mk(4'h6, 50, 500, 0, 0, 4'b0010, 0, 1, 51, 501, 1, 0, 6);
      vecs[20] = mk(4'h9, 60, 600, 0, 0, 4'b1000, 0, 1, 63, 603, 3, 0, 6);

      // Reset with live requests and a flush pending: nothing may be accepted.
      rst_n = 1'b0;
      drive(4'hF, 1, 1, 1'b1, 9);
      repeat (2) @(posedge clk);
      #1;
      check("rst_req_ready",   64'(req_ready), 0);
      check("rst_flush_ready", 64'(flush_ready), 0);
      check("rst_finishing",   64'(finishing_instr), 0);
      check("rst_flushing",    64'(flushing_instr), 0);
      check("rst_itf",         64'(instr_to_finish), 0);
      check("rst_fval",        64'(finish_val), 0);
      check("rst_itfl",        64'(instr_to_flush), 0);
      check("rst_gid",         64'(grant_id), 0);
      check("rst_hold",        64'(hold), 0);
      drive(4'h0, 0, 0, 1'b0, 0);
      @(negedge clk);
      rst_n = 1'b1;

      for (int v = 0; v < NVEC; v++) begin
         @(negedge clk);
         drive(vecs[v].rv, vecs[v].tbase, vecs[v].vbase, vecs[v].fv, vecs[v].ftag);
         #1;
         check($sformatf("v%0d_req_ready", v),   64'(req_ready), 64'(vecs[v].e_ready));
         check($sformatf("v%0d_flush_ready", v), 64'(flush_ready), 1);
         check($sformatf("v%0d_hold", v),        64'(hold), 64'(vecs[v].e_hold));
         @(posedge clk);
         #1;
         check($sformatf("v%0d_finishing", v), 64'(finishing_instr), 64'(vecs[v].e_fin));
         check($sformatf("v%0d_itf", v),       64'(instr_to_finish), 64'(vecs[v].e_itf));
         check($sformatf("v%0d_fval", v),      64'(finish_val), 64'(vecs[v].e_fval));
         check($sformatf("v%0d_gid", v),       64'(grant_id), 64'(vecs[v].e_gid));
         check($sformatf("v%0d_flushing", v),  64'(flushing_instr), 64'(vecs[v].e_fl));
         check($sformatf("v%0d_itfl", v),      64'(instr_to_flush), 64'(vecs[v].e_itfl));
      end

      // Reset asserted mid-cycle while in HOLD: outputs clear at once, pending hold dropped.
      @(negedge clk);
      drive(4'h0, 0, 0, 1'b1, 9);
      @(posedge clk);
      #1;
      check("hr_flushing", 64'(flushing_instr), 1);
      check("hr_itfl",     64'(instr_to_flush), 9);
      drive(4'hF, 1, 1, 1'b0, 0);
      #1;
      check("hr_hold", 64'(hold), 1);
      #1;
      rst_n = 1'b0;
      #1;
      check("hr_async_flushing", 64'(flushing_instr), 0);
      check("hr_async_itfl",     64'(instr_to_flush), 0);
      check("hr_async_itf",      64'(instr_to_finish), 0);
      check("hr_async_fval",     64'(finish_val), 0);
      check("hr_async_gid",      64'(grant_id), 0);
      check("hr_async_hold",     64'(hold), 0);
      check("hr_async_ready",    64'(req_ready), 0);
      check("hr_async_fready",   64'(flush_ready), 0);
      @(negedge clk);
      rst_n = 1'b1;
      drive(4'h8, 70, 700, 1'b0, 0);
      #1;
      check("hr_post_ready", 64'(req_ready), 64'b1000);
      check("hr_post_hold",  64'(hold), 0);
      @(posedge clk);
      #1;
      check("hr_post_finishing", 64'(finishing_instr), 1);
      check("hr_post_itf",       64'(instr_to_finish), 73);
      check("hr_post_fval",      64'(finish_val), 703);
      check("hr_post_gid",       64'(grant_id), 3);
      check("hr_post_flushing",  64'(flushing_instr), 0);

      // Fairness: all four held valid; requester 3 must be served within NREQ cycles.
      got3 = 1'b0;
      for (int c = 0; c < NREQ && !got3; c++) begin
         @(negedge clk);
         drive(4'hF, 80, 800, 1'b0, 0);
         @(posedge clk);
         #1;
         if (finishing_instr && grant_id == 2'd3) got3 = 1'b1;
      end
      check("starve_req3_granted", 64'(got3), 1);
      check("starve_req3_tag",     64'(instr_to_finish), 83);

      @(negedge clk);
      drive(4'h0, 0, 0, 1'b0, 0);
      @(posedge clk);
      #1;
      check("idle_finishing", 64'(finishing_instr), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule : tb_rob_finish_arb
